// File: rtl/aftab_byte_mem_master.sv
// Byte-serial initiator for the AFTAB asynchronous-handshake data memory:
// splits 1/2/4-byte requests into little-endian byte accesses with a per-byte timeout.
module aftab_byte_mem_master #(
    parameter int dataWidth     = 8,
    parameter int addressWidth  = 32,
    parameter int timeoutCycles = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    startRead,
    input  logic                    startWrite,
    input  logic [1:0]              nBytes,
    input  logic [addressWidth-1:0] addrIn,
    input  logic [31:0]             dataIn,
    output logic [31:0]             dataOut,
    output logic                    done,
    output logic                    busy,
    output logic                    timeoutErr,
    output logic                    readmem,
    output logic                    writemem,
    output logic [addressWidth-1:0] addressBus,
    output logic [dataWidth-1:0]    memDataOut,
    input  logic [dataWidth-1:0]    memDataIn,
    input  logic                    memDataReady
);

    localparam int TW = $clog2(timeoutCycles) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RELEASE, S_DONE} state_t;

    state_t                  state_q;
    logic [addressWidth-1:0] base_q;
    logic [31:0]             wdata_q;
    logic                    we_q;
    logic [1:0]              last_q;
    logic [1:0]              idx_q;
    logic [TW-1:0]           tcnt_q;
    logic [31:0]             dataOut_q;
    logic                    done_q;
    logic                    busy_q;
    logic                    timeoutErr_q;
    logic                    readmem_q;
    logic                    writemem_q;
    logic [addressWidth-1:0] addressBus_q;
    logic [dataWidth-1:0]    memDataOut_q;

    logic [1:0]              idx_next_d;
    logic [addressWidth-1:0] addr_next_d;
    logic [dataWidth-1:0]    byte_next_d;

    // Address and store byte for the following byte of the request; address wraps naturally.
    always_comb begin
        idx_next_d  = idx_q + 2'd1;
        addr_next_d = base_q + {{(addressWidth-2){1'b0}}, idx_next_d};
        byte_next_d = wdata_q[{idx_next_d, 3'b000} +: dataWidth];
    end

    // Request sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            base_q       <= {addressWidth{1'b0}};
            wdata_q      <= 32'h0;
            we_q         <= 1'b0;
            last_q       <= 2'd0;
            idx_q        <= 2'd0;
            tcnt_q       <= {TW{1'b0}};
            dataOut_q    <= 32'h0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            timeoutErr_q <= 1'b0;
            readmem_q    <= 1'b0;
            writemem_q   <= 1'b0;
            addressBus_q <= {addressWidth{1'b0}};
            memDataOut_q <= {dataWidth{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (startWrite || startRead) begin
                        base_q       <= addrIn;
                        wdata_q      <= dataIn;
                        we_q         <= startWrite;
                        // Size code 10 is treated as a full word.
                        last_q       <= (nBytes == 2'b00) ? 2'd0 : ((nBytes == 2'b01) ? 2'd1 : 2'd3);
                        idx_q        <= 2'd0;
                        tcnt_q       <= {TW{1'b0}};
                        timeoutErr_q <= 1'b0;
                        if (!startWrite) begin
                            dataOut_q <= 32'h0;
                        end
                        addressBus_q <= addrIn;
                        memDataOut_q <= dataIn[dataWidth-1:0];
                        readmem_q    <= !startWrite;
                        writemem_q   <= startWrite;
                        busy_q       <= 1'b1;
                        state_q      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (memDataReady) begin
                        if (!we_q) begin
                            dataOut_q[{idx_q, 3'b000} +: dataWidth] <= memDataIn;
                        end
                        readmem_q  <= 1'b0;
                        writemem_q <= 1'b0;
                        state_q    <= S_RELEASE;
                    end else if (tcnt_q == TW'(timeoutCycles - 1)) begin
                        readmem_q    <= 1'b0;
                        writemem_q   <= 1'b0;
                        timeoutErr_q <= 1'b1;
                        done_q       <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        tcnt_q <= tcnt_q + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                S_RELEASE: begin
                    // The memory must withdraw ready before the next byte is strobed.
                    if (!memDataReady) begin
                        if (idx_q == last_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            idx_q        <= idx_next_d;
                            addressBus_q <= addr_next_d;
                            memDataOut_q <= byte_next_d;
                            tcnt_q       <= {TW{1'b0}};
                            readmem_q    <= !we_q;
                            writemem_q   <= we_q;
                            state_q      <= S_ACCESS;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    readmem_q  <= 1'b0;
                    writemem_q <= 1'b0;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign dataOut    = dataOut_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign timeoutErr = timeoutErr_q;
    assign readmem    = readmem_q;
    assign writemem   = writemem_q;
    assign addressBus = addressBus_q;
    assign memDataOut = memDataOut_q;

endmodule

// File: tb/tb_aftab_byte_mem_master.sv
// Table-driven bench for aftab_byte_mem_master with a byte memory responder of programmable latency.
module tb_aftab_byte_mem_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        startRead = 1'b0;
    logic        startWrite = 1'b0;
    logic [1:0]  nBytes = 2'b00;
    logic [31:0] addrIn = 32'h0;
    logic [31:0] dataIn = 32'h0;
    logic [31:0] dataOut;
    logic        done, busy, timeoutErr, readmem, writemem;
    logic [31:0] addressBus;
    logic [7:0]  memDataOut;
    logic [7:0]  memDataIn;
    logic        memDataReady;

    aftab_byte_mem_master #(.dataWidth(8), .addressWidth(32), .timeoutCycles(64)) dut (
        .clk(clk), .rst(rst), .startRead(startRead), .startWrite(startWrite),
        .nBytes(nBytes), .addrIn(addrIn), .dataIn(dataIn), .dataOut(dataOut),
        .done(done), .busy(busy), .timeoutErr(timeoutErr), .readmem(readmem),
        .writemem(writemem), .addressBus(addressBus), .memDataOut(memDataOut),
        .memDataIn(memDataIn), .memDataReady(memDataReady)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Responder: ready rises 'lat' cycles after it sees the strobe, drops as soon as the strobe does.
    logic [7:0] mem [0:15];
    int         lat = 0;
    logic       noready = 1'b0;
    logic       rdy_q = 1'b0;
    int         rcnt = 0;
    logic [7:0] rdata = 8'h00;
    logic       init_done = 1'b0;

    function automatic int idx_of(input logic [31:0] a);
        if (a == 32'hFFFF_FFFF) return 15;
        return int'({a[9:8], a[1:0]});
    endfunction

    always @(posedge clk) begin
        if (!init_done) begin
            for (int k = 0; k < 16; k++) mem[k] <= 8'h00;
            mem[0]  <= 8'h77; mem[1]  <= 8'hA1; mem[2]  <= 8'hA2; mem[3]  <= 8'hA3;
            mem[4]  <= 8'h11; mem[5]  <= 8'h22; mem[6]  <= 8'h33; mem[7]  <= 8'h44;
            mem[8]  <= 8'hE0; mem[9]  <= 8'hE1; mem[10] <= 8'hE2; mem[11] <= 8'hE3;
            mem[15] <= 8'h5A;
            init_done <= 1'b1;
        end else if (!(readmem || writemem)) begin
            rdy_q <= 1'b0;
            rcnt  <= 0;
        end else if (!rdy_q && !noready) begin
            if (rcnt == lat) begin
                rdy_q <= 1'b1;
                rdata <= mem[idx_of(addressBus)];
                if (writemem) mem[idx_of(addressBus)] <= memDataOut;
            end else begin
                rcnt <= rcnt + 1;
            end
        end
    end

    assign memDataReady = rdy_q & (readmem | writemem);
    assign memDataIn    = rdata;

    // Bus monitor: logs each byte access, strobe cycles, done pulses and bus instability.
    int          nacc = 0, nrd = 0, nwr = 0, strobe_cyc = 0, done_cnt = 0, stab_err = 0;
    logic [31:0] addr_log [0:255];
    logic        prev_strobe = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [7:0]  prev_md = 8'h0;

    always @(negedge clk) begin
        if ((readmem || writemem) && !prev_strobe) begin
            addr_log[nacc[7:0]] <= addressBus;
            nacc <= nacc + 1;
            if (readmem) nrd <= nrd + 1;
            else nwr <= nwr + 1;
        end
        if ((readmem || writemem) && prev_strobe && (addressBus != prev_addr || memDataOut != prev_md))
            stab_err <= stab_err + 1;
        if (readmem || writemem) strobe_cyc <= strobe_cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
        prev_strobe <= readmem | writemem;
        prev_addr   <= addressBus;
        prev_md     <= memDataOut;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  nb;
        logic [31:0] addr;
        logic [31:0] din;
        int          lat;
        logic        nordy;
        logic [31:0] dout;
        logic        err;
        int          nacc;
        logic [31:0] last;
    } vec_t;

    task automatic run_req(input vec_t v, input string tag);
        int base_acc, base_cyc, base_done, n;
        base_acc  = nacc;
        base_cyc  = strobe_cyc;
        base_done = done_cnt;
        lat       = v.lat;
        noready   = v.nordy;
        @(negedge clk); #1;
        startWrite = v.we; startRead = !v.we;
        nBytes = v.nb; addrIn = v.addr; dataIn = v.din;
        @(negedge clk); #1;
        startWrite = 1'b0; startRead = 1'b0;
        chk({tag, "_busy_start"}, {31'h0, busy}, 32'h1);
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 400) begin
            chk({tag, "_done_wait"}, 32'h0, 32'h1);
        end else begin
            chk({tag, "_dataOut"}, dataOut, v.dout);
            chk({tag, "_timeoutErr"}, {31'h0, timeoutErr}, {31'h0, v.err});
            chk({tag, "_busy_at_done"}, {31'h0, busy}, 32'h1);
            @(negedge clk); #1;
            chk({tag, "_done_pulse_end"}, {31'h0, done}, 32'h0);
            chk({tag, "_busy_after"}, {31'h0, busy}, 32'h0);
            chk({tag, "_done_count"}, done_cnt - base_done, 32'd1);
            chk({tag, "_n_accesses"}, nacc - base_acc, v.nacc);
            chk({tag, "_first_addr"}, addr_log[base_acc[7:0]], v.addr);
            chk({tag, "_last_addr"}, addr_log[nacc[7:0] - 8'd1], v.last);
            if (v.nordy) chk({tag, "_timeout_cycles"}, strobe_cyc - base_cyc, 32'd64);
        end
        noready = 1'b0;
    endtask

    vec_t vecs [0:6];

    initial begin
        int base_acc, base_done, base_rd, base_wr, n;
        vecs[0] = '{1'b0, 2'b11, 32'h0000_0100, 32'h0,         2, 1'b0, 32'h4433_2211, 1'b0, 4, 32'h0000_0103};
        vecs[1] = '{1'b1, 2'b01, 32'h0000_0201, 32'hAABB_CCDD, 1, 1'b0, 32'h4433_2211, 1'b0, 2, 32'h0000_0202};
        vecs[2] = '{1'b0, 2'b00, 32'hFFFF_FFFF, 32'h0,         0, 1'b0, 32'h0000_005A, 1'b0, 1, 32'hFFFF_FFFF};
        vecs[3] = '{1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0,         3, 1'b0, 32'h0000_775A, 1'b0, 2, 32'h0000_0000};
        vecs[4] = '{1'b0, 2'b10, 32'h0000_0101, 32'h0,         0, 1'b0, 32'h1144_3322, 1'b0, 4, 32'h0000_0104};
        vecs[5] = '{1'b0, 2'b11, 32'h0000_0100, 32'h0,         0, 1'b1, 32'h0000_0000, 1'b1, 1, 32'h0000_0100};
        vecs[6] = '{1'b1, 2'b00, 32'h0000_0002, 32'h1234_5699, 0, 1'b0, 32'h0000_0000, 1'b0, 1, 32'h0000_0002};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {dataOut[7:0], 1'b0, done, busy, timeoutErr, readmem, writemem, addressBus[1:0], memDataOut}, 32'h0);
        chk("reset_addr", addressBus, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_req(vecs[i], $sformatf("vec%0d", i));

        chk("store_mem_200_untouched", {24'h0, mem[8]}, 32'hE0);
        chk("store_mem_201", {24'h0, mem[9]}, 32'hDD);
        chk("store_mem_202", {24'h0, mem[10]}, 32'hCC);
        chk("store_mem_203_untouched", {24'h0, mem[11]}, 32'hE3);
        chk("store_mem_002", {24'h0, mem[2]}, 32'h99);

        // Simultaneous starts: the store wins; a read pulsed while busy is dropped.
        base_done = done_cnt; base_rd = nrd; base_wr = nwr; lat = 0;
        @(negedge clk); #1;
        startRead = 1'b1; startWrite = 1'b1; nBytes = 2'b00; addrIn = 32'h0000_0203; dataIn = 32'h0000_0055;
        @(negedge clk); #1;
        startWrite = 1'b0; addrIn = 32'h0000_0100;
        @(negedge clk); #1;
        startRead = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("both_start_done_count", done_cnt - base_done, 32'd1);
        chk("both_start_writes", nwr - base_wr, 32'd1);
        chk("both_start_reads", nrd - base_rd, 32'd0);
        chk("both_start_mem_203", {24'h0, mem[11]}, 32'h55);

        // Reset while the third byte of a word store is strobed.
        base_done = done_cnt; base_acc = nacc; lat = 1;
        @(negedge clk); #1;
        startWrite = 1'b1; nBytes = 2'b11; addrIn = 32'h0000_0000; dataIn = 32'h0C0B_0A09;
        @(negedge clk); #1;
        startWrite = 1'b0;
        n = 0;
        while ((nacc - base_acc) < 3 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("rst_reach_third_byte", {31'h0, n < 200}, 32'h1);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rst_strobes_low", {30'h0, readmem, writemem}, 32'h0);
        chk("rst_busy_low", {31'h0, busy}, 32'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("rst_no_done", done_cnt - base_done, 32'd0);
        chk("rst_n_accesses", nacc - base_acc, 32'd3);
        chk("rst_mem_000", {24'h0, mem[0]}, 32'h09);
        chk("rst_mem_001", {24'h0, mem[1]}, 32'h0A);
        chk("rst_mem_002_unwritten", {24'h0, mem[2]}, 32'h99);
        chk("rst_mem_003_unwritten", {24'h0, mem[3]}, 32'hA3);

        run_req(vecs[0], "after_rst");
        chk("bus_stable_during_strobe", stab_err, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
